rv32_exec_sequencer: RTL and testbench
======================================

# rv32_exec_sequencer

Multi-cycle RV32I instruction sequencer: the initiator that drives the core's combinational ALU. It fetches one instruction over a valid/ready port and decodes it into the ALU's {num1, num2, pc, ALU_op} inputs. It consumes the ALU's out/branch results, runs load/store transactions, writes back to the register file and advances the PC. It sits between instruction memory, the register file, the ALU and data memory.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- instr_valid  in  1  instruction word available
- instr  in  32  instruction word
- instr_ready  out  1  sequencer accepts instruction
- imem_addr  out  32  current PC, for fetch
- rs1_addr, rs2_addr  out  5 each  register file read addresses
- rs1_data, rs2_data  in  32 each  register file read data, combinational from the addresses
- num1, num2  out  32 each  ALU operands
- pc  out  32  ALU pc operand (current PC)
- ALU_op  out  11  {instr[30], instr[14:12], instr[6:0]}
- alu_out  in  32  ALU result
- branch  in  1  ALU branch-taken flag
- mem_req  out  1  data memory request, held until acknowledged
- mem_we  out  1  1 = store
- mem_size  out  3  funct3 of the load/store; memory returns load data already extended
- mem_addr, mem_wdata  out  32 each  address (alu_out), store data (rs2)
- mem_rdata  in  32  load data, valid with mem_ack
- mem_ack  in  1  request complete
- rd_we  out  1  register write strobe, one cycle
- rd_addr  out  5  destination register
- rd_wdata  out  32  write data
- illegal  out  1  unsupported opcode seen; exists only when the macro below is defined

## Operation
- States: FETCH -> DECODE -> EXEC -> (MEM) -> WB -> FETCH. HALT exists only when the macro is defined.
- FETCH: instr_ready=1. On instr_valid&instr_ready, latch instr and go to DECODE.
- DECODE: drive rs1_addr=instr[19:15] and rs2_addr=instr[24:20]. Register num1, num2 and ALU_op at the clock edge.
- Operand rules:
  - num1=rs1_data.
  - num2 by type:
    - OP: rs2_data.
    - OP-IMM, LOAD, JALR: imm_I.
    - STORE: imm_S.
    - BRANCH: rs2_data.
    - LUI: imm_U.
    - AUIPC: pc+imm_U, 32-bit wrap.
    - JAL: don't-care.
- Immediates are sign-extended to 32 bits. imm_U is {instr[31:12],12'b0}.
- EXEC: ALU inputs are stable. Latch alu_out and branch at the clock edge. LOAD/STORE go to MEM; all other types go to WB.
- MEM:
  - mem_req=1, mem_addr=latched alu_out, mem_wdata=rs2, mem_we=(opcode==STORE).
  - mem_req and all mem_* outputs stay constant until mem_ack. On mem_ack, go to WB.
  - For loads, mem_rdata is latched on that edge.
- WB:
  - rd_we=1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD when rd!=0. rd_we is always 0 for rd==0.
  - rd_wdata=mem_rdata for LOAD, latched alu_out otherwise.
  - Next PC:
    - JAL: pc+imm_J.
    - JALR: (rs1+imm_I)&~1.
    - BRANCH with branch=1: pc+imm_B.
    - All other cases: pc+4.
  - All PC arithmetic is modulo 2^32.
- Unsupported opcodes (FENCE, SYSTEM, unknown): treated as NOP; PC advances by 4.
- Reset values: state FETCH, PC=RESET_PC, instr register 0. All outputs 0, except imem_addr/pc=RESET_PC and instr_ready=1 after release.

## Timing
- Non-memory instruction: 4 cycles minimum, counted from instr_valid high in FETCH to the next FETCH.
- Load/store: 5 cycles plus data memory wait cycles.
- instr_ready is high only in FETCH. An instruction offered in any other state is not consumed.
- rd_we and the PC update take effect on the same edge, when leaving WB.
- mem_ack outside MEM is ignored.
- Reset mid-operation clears state, PC and strobes immediately and asynchronously. An in-flight memory request is abandoned; mem_req drops with rst.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An unsupported opcode in DECODE goes to HALT.
  - HALT: illegal=1, instr_ready=0, no writes, PC frozen.
  - Only rst leaves HALT.
- ILLEGAL_TRAP_EN undefined: illegal port and HALT state are absent; unsupported opcodes are NOPs.

## Test plan
- ADDI x1,x0,5 (32'h00500093) at RESET_PC=0, ALU model attached -> ALU_op=11'b00000010011, num2=5; rd_we with rd=1, wdata=5 in cycle 4; next imem_addr=4.
- BEQ x0,x0,+8 (32'h00000463) at pc=0x10 -> branch=1 latched; next PC=0x18, no rd_we. With rs1≠rs2 -> next PC=0x14.
- JALR x1,0(x2), x2=0x103 -> rd_wdata=pc+4, next PC=0x102.
- LW x3,4(x2), x2=0x100, mem_ack delayed 3 cycles -> mem_req held with addr 0x104 and mem_we=0 until ack; rd_wdata=mem_rdata (0xDEADBEEF) to x3.
- ADD x0,x1,x2 -> no rd_we. Assert rst during MEM of a SW -> mem_req=0 at once, PC=RESET_PC, FETCH.
- Opcode 7'b1111111: with ILLEGAL_TRAP_EN -> illegal=1, instr_ready stays 0 until rst. Without it -> PC+4, no writes.

Source files
------------

// File: rtl/rv32_exec_sequencer.sv
// Multi-cycle RV32I sequencer: fetch, decode into ALU operands, memory access, write-back, PC update.
// Optional ILLEGAL_TRAP_EN macro: unsupported opcodes halt the sequencer and raise 'illegal'.
module rv32_exec_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] imem_addr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] num1,
  output logic [31:0] num2,
  output logic [31:0] pc,
  output logic [10:0] ALU_op,
  input  logic [31:0] alu_out,
  input  logic        branch,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
`else
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
`endif

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, instr_reg, num1_reg, num2_reg, rs2_reg;
  logic [31:0] alu_out_reg, rdata_reg, num2_next, pc_next;
  logic [10:0] alu_op_reg;
  logic        branch_reg;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        is_load, is_store, is_jal, is_jalr, is_branch, writes_rd;

  assign opcode = instr_reg[6:0];
  assign rd     = instr_reg[11:7];
  assign funct3 = instr_reg[14:12];
  assign imm_i  = {{20{instr_reg[31]}}, instr_reg[31:20]};
  assign imm_s  = {{20{instr_reg[31]}}, instr_reg[31:25], instr_reg[11:7]};
  assign imm_b  = {{19{instr_reg[31]}}, instr_reg[31], instr_reg[7], instr_reg[30:25], instr_reg[11:8], 1'b0};
  assign imm_u  = {instr_reg[31:12], 12'b0};
  assign imm_j  = {{11{instr_reg[31]}}, instr_reg[31], instr_reg[19:12], instr_reg[20], instr_reg[30:21], 1'b0};

  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign writes_rd = (opcode == OPC_OP) || (opcode == OPC_OPIMM) || (opcode == OPC_LUI) ||
                     (opcode == OPC_AUIPC) || is_jal || is_jalr || is_load;

  // Register file addresses come straight from the latched word; data is valid during DECODE.
  assign rs1_addr = instr_reg[19:15];
  assign rs2_addr = instr_reg[24:20];

  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign num1      = num1_reg;
  assign num2      = num2_reg;
  assign ALU_op    = alu_op_reg;

  assign mem_req   = (state_reg == MEM);
  assign mem_we    = mem_req && is_store;
  assign mem_size  = mem_req ? funct3 : 3'b000;
  assign mem_addr  = mem_req ? alu_out_reg : 32'h0;
  assign mem_wdata = mem_req ? rs2_reg : 32'h0;

  assign rd_we    = (state_reg == WB) && writes_rd && (rd != 5'd0);
  assign rd_addr  = (state_reg == WB) ? rd : 5'd0;
  assign rd_wdata = (state_reg == WB) ? (is_load ? rdata_reg : alu_out_reg) : 32'h0;

`ifdef ILLEGAL_TRAP_EN
  logic supported;
  assign supported = writes_rd || is_store || is_branch;
  assign illegal   = (state_reg == HALT);
`endif

  always_comb begin
    num2_next = 32'h0;
    case (opcode)
      OPC_OP, OPC_BRANCH:             num2_next = rs2_data;
      OPC_OPIMM, OPC_LOAD, OPC_JALR:  num2_next = imm_i;
      OPC_STORE:                      num2_next = imm_s;
      OPC_LUI:                        num2_next = imm_u;
      OPC_AUIPC:                      num2_next = pc_reg + imm_u;
      default:                        num2_next = 32'h0;
    endcase
  end

  // JALR target uses the rs1 value captured as num1 during DECODE.
  always_comb begin
    pc_next = pc_reg + 32'd4;
    if (is_jal)
      pc_next = pc_reg + imm_j;
    else if (is_jalr)
      pc_next = (num1_reg + imm_i) & ~32'd1;
    else if (is_branch && branch_reg)
      pc_next = pc_reg + imm_b;
  end

  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    case (state_reg)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid)
          state_next = DECODE;
      end
`ifdef ILLEGAL_TRAP_EN
      DECODE:  state_next = supported ? EXEC : HALT;
      HALT:    state_next = HALT;
`else
      DECODE:  state_next = EXEC;
`endif
      EXEC:    state_next = (is_load || is_store) ? MEM : WB;
      MEM:     state_next = mem_ack ? WB : MEM;
      WB:      state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= FETCH;
      pc_reg      <= RESET_PC;
      instr_reg   <= 32'h0;
      num1_reg    <= 32'h0;
      num2_reg    <= 32'h0;
      rs2_reg     <= 32'h0;
      alu_op_reg  <= 11'h0;
      alu_out_reg <= 32'h0;
      branch_reg  <= 1'b0;
      rdata_reg   <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (state_reg == FETCH && instr_valid)
        instr_reg <= instr;
      if (state_reg == DECODE) begin
        num1_reg   <= rs1_data;
        num2_reg   <= num2_next;
        rs2_reg    <= rs2_data;
        alu_op_reg <= {instr_reg[30], instr_reg[14:12], instr_reg[6:0]};
      end
      if (state_reg == EXEC) begin
        alu_out_reg <= alu_out;
        branch_reg  <= branch;
      end
      if (state_reg == MEM && mem_ack && is_load)
        rdata_reg <= mem_rdata;
      if (state_reg == WB)
        pc_reg <= pc_next;
    end
  end

endmodule

// File: tb/tb_rv32_exec_sequencer.sv
// Bench for rv32_exec_sequencer: ALU, register file and data memory models around the DUT,
// with an expected-result queue checked as each instruction retires.
module tb_rv32_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] imem_addr;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] num1, num2, pc;
  logic [10:0] ALU_op;
  logic [31:0] alu_out;
  logic        branch;
  logic        mem_req, mem_we;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  always #5 clk = ~clk;

  rv32_exec_sequencer #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready), .imem_addr(imem_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .num1(num1), .num2(num2), .pc(pc), .ALU_op(ALU_op), .alu_out(alu_out), .branch(branch),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  // Reference ALU
  logic [6:0] a_opc;
  logic [2:0] a_f3;
  assign a_opc = ALU_op[6:0];
  assign a_f3  = ALU_op[9:7];
  always_comb begin
    alu_out = 32'h0;
    branch  = 1'b0;
    case (a_opc)
      7'h33, 7'h13: begin
        case (a_f3)
          3'd0: alu_out = (a_opc == 7'h33 && ALU_op[10]) ? num1 - num2 : num1 + num2;
          3'd1: alu_out = num1 << num2[4:0];
          3'd2: alu_out = {31'h0, $signed(num1) < $signed(num2)};
          3'd3: alu_out = {31'h0, num1 < num2};
          3'd4: alu_out = num1 ^ num2;
          3'd5: alu_out = ALU_op[10] ? 32'($signed(num1) >>> num2[4:0]) : num1 >> num2[4:0];
          3'd6: alu_out = num1 | num2;
          default: alu_out = num1 & num2;
        endcase
      end
      7'h03, 7'h23: alu_out = num1 + num2;
      7'h37, 7'h17: alu_out = num2;
      7'h6F, 7'h67: alu_out = pc + 32'd4;
      7'h63: begin
        case (a_f3)
          3'd0: branch = (num1 == num2);
          3'd1: branch = (num1 != num2);
          3'd4: branch = $signed(num1) < $signed(num2);
          3'd5: branch = $signed(num1) >= $signed(num2);
          3'd6: branch = num1 < num2;
          3'd7: branch = num1 >= num2;
          default: branch = 1'b0;
        endcase
      end
      default: alu_out = 32'h0;
    endcase
  end

  // Register file model
  logic [31:0] regs [32];
  assign rs1_data = (rs1_addr == 5'd0) ? 32'h0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'h0 : regs[rs2_addr];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (rd_we && rd_addr != 5'd0) begin
      regs[rd_addr] <= rd_wdata;
    end
  end

  // Write-back monitor: cumulative counters only
  int          we_total = 0;
  logic [4:0]  we_last_addr;
  logic [31:0] we_last_data;
  always @(negedge clk) begin
    if (rd_we) begin
      we_total++;
      we_last_addr = rd_addr;
      we_last_data = rd_wdata;
    end
  end

  // Data memory responder
  int          ack_delay = 0;
  logic [31:0] load_val = 32'h0;
  int          req_cnt = 0;
  int          req_last_cycles = 0;
  int          req_unstable = 0;
  logic [31:0] req_addr, req_wdata;
  logic        req_we;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (req_cnt == 0) begin
          req_addr  = mem_addr;
          req_we    = mem_we;
          req_wdata = mem_wdata;
        end else if (mem_addr !== req_addr || mem_we !== req_we || mem_wdata !== req_wdata) begin
          req_unstable++;
        end
        req_cnt++;
        mem_ack   = (req_cnt > ack_delay);
        mem_rdata = mem_ack ? load_val : 32'h0;
        if (mem_ack) req_last_cycles = req_cnt;
      end else begin
        req_cnt   = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] npc;
    int          cycles;
  } exp_t;
  exp_t sb[$];

  logic [31:0] cap_num1, cap_num2;
  logic [10:0] cap_op;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rdx, logic [6:0] op);
    return {imm, rs1, f3, rdx, op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rdx);
    return {f7, rs2, rs1, f3, rdx, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rdx, logic [6:0] op);
    return {imm, rdx, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rdx);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rdx, 7'h6F};
  endfunction

  // Issue one instruction from FETCH (called at a negedge) and check it on retirement.
  task automatic run_instr(input string tag, input logic [31:0] word, input logic we,
                           input logic [4:0] rdx, input logic [31:0] wdata,
                           input logic [31:0] npc, input int cycles);
    exp_t e;
    int   we_before, n;
    bit   done;
    sb.push_back('{we, rdx, wdata, npc, cycles});
    we_before   = we_total;
    instr_valid = 1'b1;
    instr       = word;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 32'h0;
    n = 0;
    done = 1'b0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        cap_num1 = num1;
        cap_num2 = num2;
        cap_op   = ALU_op;
      end
      if (instr_ready) done = 1'b1;
    end
    e = sb.pop_front();
    check({tag, " retire"}, {31'h0, done}, 32'h1);
    check({tag, " cycles"}, n, e.cycles);
    check({tag, " next_pc"}, imem_addr, e.npc);
    check({tag, " rd_we_count"}, we_total - we_before, {31'h0, e.we});
    if (e.we) begin
      check({tag, " rd_addr"}, {27'h0, we_last_addr}, {27'h0, e.rd});
      check({tag, " rd_wdata"}, we_last_data, e.wdata);
    end
    $display("[TB] %s instr=%h cycles=%0d pc_after=%h", tag, word, n, imem_addr);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 32'h0;
    repeat (3) @(negedge clk);
    check("rst mem_req", {31'h0, mem_req}, 32'h0);
    check("rst rd_we", {31'h0, rd_we}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("reset imem_addr", imem_addr, 32'h0);
    check("reset pc", pc, 32'h0);
    check("reset instr_ready", {31'h0, instr_ready}, 32'h1);
    check("reset num1", num1, 32'h0);
    check("reset num2", num2, 32'h0);
    check("reset ALU_op", {21'h0, ALU_op}, 32'h0);

    run_instr("ADDI x1,x0,5", enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 1'b1, 5'd1, 32'd5, 32'h4, 4);
    check("ADDI ALU_op", {21'h0, cap_op}, 32'h013);
    check("ADDI num2", cap_num2, 32'd5);
    run_instr("ADDI x2,x0,0x100", enc_i(12'h100, 5'd0, 3'd0, 5'd2, 7'h13), 1'b1, 5'd2, 32'h100, 32'h8, 4);

    ack_delay = 3;
    load_val  = 32'hDEADBEEF;
    run_instr("LW x3,4(x2)", enc_i(12'd4, 5'd2, 3'd2, 5'd3, 7'h03), 1'b1, 5'd3, 32'hDEADBEEF, 32'hC, 8);
    check("LW mem_addr", req_addr, 32'h104);
    check("LW mem_we", {31'h0, req_we}, 32'h0);
    check("LW req cycles", req_last_cycles, 4);
    check("LW req stable", req_unstable, 0);
    ack_delay = 0;

    run_instr("ADD x0,x1,x2", enc_r(7'h0, 5'd2, 5'd1, 3'd0, 5'd0), 1'b0, 5'd0, 32'h0, 32'h10, 4);
    run_instr("BEQ x0,x0,+8", enc_b(13'd8, 5'd0, 5'd0, 3'd0), 1'b0, 5'd0, 32'h0, 32'h18, 4);
    run_instr("BEQ x1,x2,+8", enc_b(13'd8, 5'd2, 5'd1, 3'd0), 1'b0, 5'd0, 32'h0, 32'h1C, 4);
    run_instr("ADDI x2,x0,0x103", enc_i(12'h103, 5'd0, 3'd0, 5'd2, 7'h13), 1'b1, 5'd2, 32'h103, 32'h20, 4);
    run_instr("JALR x1,0(x2)", enc_i(12'd0, 5'd2, 3'd0, 5'd1, 7'h67), 1'b1, 5'd1, 32'h24, 32'h102, 4);
    run_instr("ADD x4,x1,x3", enc_r(7'h0, 5'd3, 5'd1, 3'd0, 5'd4), 1'b1, 5'd4, 32'hDEADBF13, 32'h106, 4);
    run_instr("LUI x5", enc_u(20'h12345, 5'd5, 7'h37), 1'b1, 5'd5, 32'h12345000, 32'h10A, 4);
    run_instr("AUIPC x6", enc_u(20'h00001, 5'd6, 7'h17), 1'b1, 5'd6, 32'h110A, 32'h10E, 4);
    run_instr("JAL x7,+0x20", enc_j(21'h20, 5'd7), 1'b1, 5'd7, 32'h112, 32'h12E, 4);

    // Store interrupted by reset while the request is outstanding
    ack_delay   = 1000;
    instr_valid = 1'b1;
    instr       = enc_s(12'd8, 5'd1, 5'd2, 3'd2);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 32'h0;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("SW mem_req seen", {31'h0, mem_req}, 32'h1);
    check("SW mem_we", {31'h0, mem_we}, 32'h1);
    check("SW mem_addr", mem_addr, 32'h10B);
    check("SW mem_wdata", mem_wdata, 32'h24);
    check("SW mem_size", {29'h0, mem_size}, 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("SW rst mem_req", {31'h0, mem_req}, 32'h0);
    check("SW rst imem_addr", imem_addr, 32'h0);
    check("SW rst rd_we", {31'h0, rd_we}, 32'h0);
    check("SW rst instr_ready", {31'h0, instr_ready}, 32'h1);
    $display("[TB] SW x1,8(x2) aborted by reset, imem_addr=%h", imem_addr);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    check("post-rst instr_ready", {31'h0, instr_ready}, 32'h1);
    run_instr("ADDI x1,x0,5 post-rst", enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 1'b1, 5'd1, 32'd5, 32'h4, 4);

`ifdef ILLEGAL_TRAP_EN
    instr_valid = 1'b1;
    instr       = 32'h0000007F;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 32'h0;
    repeat (10) @(negedge clk);
    check("ILL illegal", {31'h0, illegal}, 32'h1);
    check("ILL instr_ready", {31'h0, instr_ready}, 32'h0);
    check("ILL pc frozen", imem_addr, 32'h4);
    check("ILL rd_we", {31'h0, rd_we}, 32'h0);
    $display("[TB] ILLEGAL halt instr=0000007f pc=%h", imem_addr);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ILL rst illegal", {31'h0, illegal}, 32'h0);
    check("ILL rst instr_ready", {31'h0, instr_ready}, 32'h1);
`else
    run_instr("OPC 0x7F nop", 32'h0000007F, 1'b0, 5'd0, 32'h0, 32'h8, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
